// File: rtl/tt_um_interval_capture.sv
// Interval capture tile: measures high-pulse width or rising-to-rising period
// of an asynchronous input in clk cycles, with valid/ack handshake and overflow.
module tt_um_interval_capture #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_MEASURE   = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    logic                   sig_i;
    logic                   arm_i;
    logic                   mode_i;
    logic                   ack_i;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic                   s_cur;
    logic                   rise;
    logic                   fall;
    logic                   end_evt;

    state_t                 state_q;
    logic [7:0]             count_q;
    logic                   ovf_q;
    logic                   mode_q;
    logic [7:0]             result_q;
    logic                   overflow_q;
    logic                   valid_q;
    logic                   busy_q;

    logic                   unused_inputs;

    assign sig_i  = ui_in[0];
    assign arm_i  = ui_in[1];
    assign mode_i = ui_in[2];
    assign ack_i  = ui_in[3];

    assign unused_inputs = &{1'b0, ui_in[7:4], uio_in};

    assign s_cur   = sync_q[SYNC_STAGES-1];
    assign rise    = s_cur & ~s_prev_q;
    assign fall    = ~s_cur & s_prev_q;
    // The end event uses the mode latched at the start edge, not the live pin.
    assign end_evt = mode_q ? rise : fall;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_q     <= '0;
            s_prev_q   <= 1'b0;
            state_q    <= ST_IDLE;
            count_q    <= 8'd0;
            ovf_q      <= 1'b0;
            mode_q     <= 1'b0;
            result_q   <= 8'd0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else if (ena) begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_i};
            s_prev_q <= s_cur;

            case (state_q)
                ST_IDLE: begin
                    if (arm_i) begin
                        state_q <= ST_WAIT_EDGE;
                        busy_q  <= 1'b1;
                    end
                end

                ST_WAIT_EDGE: begin
                    if (!arm_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (rise) begin
                        state_q <= ST_MEASURE;
                        count_q <= 8'd1;
                        ovf_q   <= 1'b0;
                        mode_q  <= mode_i;
                    end
                end

                ST_MEASURE: begin
                    // Abort wins over a coincident end event.
                    if (!arm_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (end_evt) begin
                        state_q    <= ST_DONE;
                        result_q   <= count_q;
                        overflow_q <= ovf_q;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b0;
                    end else if (count_q == 8'hFF) begin
                        ovf_q <= 1'b1;
                    end else begin
                        count_q <= count_q + 8'd1;
                    end
                end

                ST_DONE: begin
                    if (ack_i) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign uo_out  = result_q;
    assign uio_out = {5'b00000, busy_q, overflow_q, valid_q};
    assign uio_oe  = 8'b0000_0111;

endmodule

// File: tb/tb_tt_um_interval_capture.sv
// Bench for tt_um_interval_capture: directed handshake/reset/enable cases plus
// randomized pulse and period measurements against an arithmetic reference.
module tb_tt_um_interval_capture;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic sig, arm, mode, ack;
    int   total;
    int   bad;

    assign ui_in  = {4'b0000, ack, mode, arm, sig};
    assign uio_in = 8'h00;

    tt_um_interval_capture #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: duration in cycles from the start edge to the end edge,
    // saturated to 8 bits, overflow only when strictly beyond 255.
    function automatic void ref_measure(input int md, input int hi, input int lo,
                                        output int res, output int ovf);
        int n;
        n   = (md == 0) ? hi : hi + lo;
        res = (n > 255) ? 255 : n;
        ovf = (n > 255) ? 1 : 0;
    endfunction

    // End edge was just driven; VALID must appear after exactly three edges.
    task automatic wait_done(input string tag, input int exp_res, input int exp_ovf);
        int lat;
        lat = 0;
        while (uio_out[0] !== 1'b1 && lat < 10) begin
            tick(1);
            lat++;
        end
        check_val({tag, ".latency"}, lat, 3);
        check_val({tag, ".result"}, uo_out, exp_res);
        check_val({tag, ".ovf"}, uio_out[1], exp_ovf);
        check_val({tag, ".busy"}, uio_out[2], 0);
    endtask

    task automatic run_meas(input string tag, input int md, input int hi, input int lo,
                            input bit do_ack);
        int exp_res, exp_ovf;
        ref_measure(md, hi, lo, exp_res, exp_ovf);
        arm  = 1'b1;
        ack  = 1'b0;
        sig  = 1'b0;
        mode = md[0];
        tick(4);
        sig = 1'b1;
        for (int i = 0; i < hi; i++) begin
            tick(1);
            // Start edge already latched the mode; flipping it must not matter.
            if (i == 2) mode = ~mode;
        end
        sig = 1'b0;
        if (md == 1) begin
            tick(lo);
            check_val({tag, ".busy_mid"}, uio_out[2], 1);
            sig = 1'b1;
        end
        wait_done(tag, exp_res, exp_ovf);
        sig = 1'b0;
        if (do_ack) begin
            ack = 1'b1;
            tick(1);
            check_val({tag, ".ack_clr"}, uio_out[0], 0);
            ack = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sig   = 1'b0;
        arm   = 1'b0;
        mode  = 1'b0;
        ack   = 1'b0;
        ena   = 1'b1;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check_val("reset.result", uo_out, 0);
        check_val("reset.uio_out", uio_out, 0);
        check_val("reset.uio_oe", uio_oe, 8'h07);

        run_meas("pulse10", 0, 10, 0, 1'b1);
        run_meas("period20", 1, 8, 12, 1'b1);
        run_meas("sat300", 0, 300, 0, 1'b1);
        run_meas("sat255", 0, 255, 0, 1'b1);
        run_meas("w254", 0, 254, 0, 1'b1);
        run_meas("w1", 0, 1, 0, 1'b1);
        run_meas("w254b", 0, 254, 0, 1'b1);

        // Signal already high when armed: its fall must not be captured.
        arm = 1'b0;
        tick(2);
        sig = 1'b1;
        tick(4);
        arm = 1'b1;
        tick(4);
        sig = 1'b0;
        tick(6);
        check_val("prehigh.valid", uio_out[0], 0);
        check_val("prehigh.busy", uio_out[2], 1);
        check_val("prehigh.result", uo_out, 254);
        run_meas("prehigh5", 0, 5, 0, 1'b1);

        // ACK during MEASURE is ignored, then ARM drop aborts.
        arm = 1'b1;
        tick(4);
        sig = 1'b1;
        tick(6);
        ack = 1'b1;
        tick(2);
        ack = 1'b0;
        check_val("ackmeas.busy", uio_out[2], 1);
        check_val("ackmeas.valid", uio_out[0], 0);
        arm = 1'b0;
        tick(2);
        check_val("abort.busy", uio_out[2], 0);
        check_val("abort.valid", uio_out[0], 0);
        check_val("abort.result", uo_out, 5);
        sig = 1'b0;
        ack = 1'b1;
        tick(2);
        check_val("ackidle.uio", uio_out, 0);
        ack = 1'b0;

        // In DONE, ARM toggling and new pulses cause no capture until ACK.
        run_meas("done7", 0, 7, 0, 1'b0);
        arm = 1'b0;
        tick(2);
        arm = 1'b1;
        tick(2);
        sig = 1'b1;
        tick(4);
        sig = 1'b0;
        tick(6);
        check_val("done.valid", uio_out[0], 1);
        check_val("done.result", uo_out, 7);
        check_val("done.busy", uio_out[2], 0);
        ack = 1'b1;
        tick(1);
        check_val("ackarm.step1", uio_out, 0);
        ack = 1'b0;
        tick(1);
        check_val("ackarm.step2_busy", uio_out[2], 1);

        // Asynchronous reset mid-measurement.
        tick(2);
        sig = 1'b1;
        tick(5);
        #2 rst_n = 1'b1;
        #1;
        check_val("rstmid.result", uo_out, 0);
        check_val("rstmid.uio_out", uio_out, 0);
        check_val("rstmid.uio_oe", uio_oe, 8'h07);
        tick(2);
        rst_n = 1'b0;
        sig   = 1'b0;
        tick(2);

        // Enable held low for 5 of 10 high cycles freezes everything.
        arm  = 1'b1;
        mode = 1'b0;
        tick(4);
        sig = 1'b1;
        tick(3);
        ena = 1'b0;
        tick(5);
        ena = 1'b1;
        tick(2);
        sig = 1'b0;
        wait_done("ena_stall", 5, 0);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;

        for (int i = 0; i < 24; i++) begin
            int md, hi, lo, r;
            md = int'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 3));
            hi = (r == 0) ? int'($urandom_range(250, 300)) : int'($urandom_range(3, 120));
            lo = int'($urandom_range(1, 150));
            run_meas($sformatf("rnd%0d_m%0d_h%0d_l%0d", i, md, hi, lo), md, hi, lo, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_um_interval_capture.md
# tt_um_interval_capture

Measures the duration of an external digital signal in clock cycles: either the high-pulse width or the rising-to-rising period, selected at run time. It is the read-side companion to the 8-bit programmable counter tile. It converts an incoming waveform back into an 8-bit count with a valid/acknowledge handshake, an overflow flag and a busy indication. It sits on the standard tile pin interface (ui/uo/uio) and runs in the single `clk` domain; the measured input is asynchronous.

## Interface
- SYNC_STAGES, 2: synchronizer flops on SIG_IN; legal values ≥ 2.
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-high; clock clk.
- ena  input  1  tile enable; when low, all state and outputs hold (no counting, no transitions).
- ui_in  input  8  [0] SIG_IN (asynchronous measured signal); [1] ARM (level, capture enable); [2] MODE (0 = high-pulse width, 1 = rising-to-rising period); [3] ACK (clears VALID); [7:4] unused.
- uo_out  output  8  RESULT: last completed measurement.
- uio_in  input  8  unused.
- uio_out  output  8  [0] VALID, [1] OVERFLOW, [2] BUSY, [7:3] = 0.
- uio_oe  output  8  constant 8'b0000_0111.

## Operation
- Synchronizer: SIG_IN passes through SYNC_STAGES flops giving `s`. One further flop gives `s_d`. rise = s & ~s_d; fall = ~s & s_d.
- Reset: state = IDLE, count = 0, RESULT = 0, VALID = 0, OVERFLOW = 0, BUSY = 0. All synchronizer flops = 0.
- States: IDLE, WAIT_EDGE, MEASURE, DONE. BUSY = 1 in WAIT_EDGE or MEASURE.
- IDLE: ARM = 1 → WAIT_EDGE. ACK is ignored.
- WAIT_EDGE:
  - rise → MEASURE with count ← 1.
  - ARM = 0 → IDLE (abort; RESULT, OVERFLOW unchanged).
  - A signal already high on arming is not measured; a fresh rise is required.
- MEASURE:
  - End event: fall if MODE = 0, rise if MODE = 1.
  - On the end event, RESULT ← count, OVERFLOW ← ovf, VALID ← 1, → DONE.
  - Otherwise count ← count + 1, saturating at 255; the internal ovf sticky bit sets when an increment is attempted at 255.
  - ARM = 0 → IDLE (abort, no update). Abort has priority over the end event in the same cycle.
- DONE:
  - VALID stays 1 and RESULT is held.
  - ACK = 1 → IDLE, VALID ← 0.
  - ARM is ignored until ACK is seen.
- MODE is sampled only on the cycle rise is detected in WAIT_EDGE and is latched for the measurement. Changes mid-measurement have no effect.
- count and ovf clear on entry to MEASURE.
- RESULT and OVERFLOW change only at measurement completion or reset.

## Timing
- Input latency: a SIG_IN edge sampled at clock edge k is seen as rise/fall at edge k + SYNC_STAGES.
- Measured value:
  - N = number of clk cycles between the start-edge detection and the end-edge detection.
  - A signal driven synchronously high for exactly N cycles gives RESULT = N for 1 ≤ N ≤ 254.
  - Any N ≥ 255 gives RESULT = 255; OVERFLOW = 1 only if N > 255.
- Completion: RESULT and VALID update on the clock edge that detects the end event, and are visible the next cycle.
- ACK handshake: ACK high at edge k in DONE gives VALID = 0 after edge k. A new ARM is accepted at edge k+1 at the earliest.
- ACK and ARM high simultaneously in DONE: DONE → IDLE → WAIT_EDGE on two consecutive edges.
- Reset mid-operation: asynchronous return to reset values. A measurement in progress is discarded.
- ena = 0 freezes the synchronizer, FSM and counter. Edges occurring while frozen may be lost; this is accepted.

## Test plan
- Pulse width: MODE = 0, ARM = 1, SIG_IN high for 10 cycles → VALID = 1, RESULT = 10, OVERFLOW = 0, BUSY = 0; ACK → VALID = 0 next cycle.
- Period: MODE = 1, square wave with period 20 (8 high / 12 low) → RESULT = 20. Changing MODE mid-measurement leaves RESULT = 20.
- Saturation: MODE = 0, pulse of 300 cycles → RESULT = 255, OVERFLOW = 1. A following 255-cycle pulse → RESULT = 255, OVERFLOW = 0.
- Pre-high input: SIG_IN already high when ARM rises → no capture on its fall. The next full 5-cycle pulse → RESULT = 5.
- Abort and handshake:
  - ARM dropped mid-MEASURE → IDLE, VALID = 0, RESULT keeps its prior value.
  - In DONE, ARM toggling without ACK causes no new capture.
  - ACK asserted in IDLE or MEASURE has no effect.
- Reset and enable:
  - rst_n pulsed mid-MEASURE → all outputs 0 immediately, uio_oe = 8'h07.
  - ena = 0 for 5 cycles inside a 10-cycle-high window, with clocks running → count frozen during the stall, RESULT = 5.
